// File: rtl/write_back.sv
// Write-back stage: selects register-file data, resolves jump/branch redirects,
// and services UART-read instructions from a small receive FIFO, stalling when it is empty.
module write_back #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int RX_DEPTH_LOG2  = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      RegWrite,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                Branch,
  input  logic                      UARTtoReg,
  input  logic [31:0]               read_data,
  input  logic [31:0]               alu_result,
  input  logic [4:0]                rdist,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic [INST_MEM_WIDTH-1:0] pc2,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic                      reg_we,
  output logic [4:0]                reg_waddr,
  output logic [31:0]               reg_wdata,
  output logic                      pc_redirect,
  output logic [INST_MEM_WIDTH-1:0] pc_target,
  output logic                      stall,
  output logic                      dbg_state
);

  localparam int DEPTH = 1 << RX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] FULL_COUNT = (RX_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, WAIT_RX = 1'b1} state_t;

  state_t                   state;
  logic [7:0]               rx_mem [DEPTH];
  logic [RX_DEPTH_LOG2-1:0] wptr;
  logic [RX_DEPTH_LOG2-1:0] rptr;
  logic [RX_DEPTH_LOG2:0]   count;

  logic empty, full, uart_rd, push, pop;
  logic [31:0] sel_data;

  wire unused_inst_bits = ^inst_index;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign rx_ready = reset && !full;
  assign push     = rx_valid && rx_ready;

  // A read waiting on the FIFO stalls in either state; the pop happens the
  // first cycle the FIFO holds data, so both states share one condition.
  assign uart_rd = UARTtoReg && RegWrite;
  assign pop     = reset && uart_rd && !empty;
  assign stall   = reset && uart_rd && empty;

  assign reg_waddr   = rdist;
  assign reg_we      = reset && RegWrite && (rdist != 5'd0) && (!UARTtoReg || pop);
  assign pc_redirect = reset && (Branch != 2'b00) && !stall;
  assign dbg_state   = (state == WAIT_RX);

  always_comb begin
    sel_data = alu_result;
    case (MemtoReg)
      2'b01:   sel_data = read_data;
      2'b10:   sel_data = {{(32 - INST_MEM_WIDTH){1'b0}}, pc1};
      default: sel_data = alu_result;
    endcase
  end

  assign reg_wdata = UARTtoReg ? {24'b0, rx_mem[rptr]} : sel_data;

  always_comb begin
    pc_target = '0;
    case (Branch)
      2'b01:   pc_target = inst_index[INST_MEM_WIDTH-1:0];
      2'b10:   pc_target = alu_result[INST_MEM_WIDTH-1:0];
      2'b11:   pc_target = pc2;
      default: pc_target = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) rx_mem[wptr] <= rx_data;
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (stall) state <= WAIT_RX;
        WAIT_RX: if (pop || !uart_rd) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_back.sv
// Directed self-checking bench for write_back: write-back mux, redirects,
// UART FIFO reads, stall/release, FIFO full/wrap and reset during a stall.
module tb_write_back;

  logic        CLK;
  logic        reset;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic [1:0]  Branch;
  logic        UARTtoReg;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic [4:0]  rdist;
  logic [25:0] inst_index;
  logic [1:0]  pc1;
  logic [1:0]  pc2;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        pc_redirect;
  logic [1:0]  pc_target;
  logic        stall;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  write_back #(.INST_MEM_WIDTH(2), .RX_DEPTH_LOG2(2)) dut (
    .CLK(CLK), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .Branch(Branch), .UARTtoReg(UARTtoReg), .read_data(read_data),
    .alu_result(alu_result), .rdist(rdist), .inst_index(inst_index),
    .pc1(pc1), .pc2(pc2), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .stall(stall), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    RegWrite = 0; MemtoReg = 2'b00; Branch = 2'b00; UARTtoReg = 0;
    read_data = 32'h0; alu_result = 32'h0; rdist = 5'd0; inst_index = 26'h0;
    pc1 = 2'd0; pc2 = 2'd0; rx_valid = 0; rx_data = 8'h0;
  endtask

  task automatic uart_read(input logic [4:0] rd);
    RegWrite = 1; UARTtoReg = 1; rdist = rd;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    RegWrite = 1; rdist = 5'd5; Branch = 2'b01; UARTtoReg = 1; rx_valid = 1; rx_data = 8'h99;
    tick(); tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got %b exp 0", reg_we); end
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b exp 0", pc_redirect); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b exp 0", rx_ready); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", dbg_state); end
    clear_inputs();
    reset = 1;
    #1;
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL release_rx_ready got %b exp 1", rx_ready); end
  endtask

  task automatic test_alu_write();
    clear_inputs();
    RegWrite = 1; alu_result = 32'h0000_1234; rdist = 5'd5; read_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (reg_we !== 1'b1) begin errors++; $display("FAIL alu_we got %b exp 1", reg_we); end
    checks++; if (reg_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0d exp 5", reg_waddr); end
    checks++; if (reg_wdata !== 32'h1234) begin errors++; $display("FAIL alu_wdata got %h exp 00001234", reg_wdata); end
    MemtoReg = 2'b01; #1;
    checks++; if (reg_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mem_wdata got %h exp deadbeef", reg_wdata); end
    MemtoReg = 2'b11; #1;
    checks++; if (reg_wdata !== 32'h1234) begin errors++; $display("FAIL reserved_wdata got %h exp 00001234", reg_wdata); end
    MemtoReg = 2'b00; rdist = 5'd0; #1;
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL r0_we got %b exp 0", reg_we); end
    rdist = 5'd5; RegWrite = 0; #1;
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL nowrite_we got %b exp 0", reg_we); end
    tick();
  endtask

  task automatic test_link_jumps();
    clear_inputs();
    RegWrite = 1; rdist = 5'd31; MemtoReg = 2'b10; pc1 = 2'd3; alu_result = 32'hFFFF_FFF5;
    #1;
    checks++; if (reg_wdata !== 32'd3) begin errors++; $display("FAIL link_wdata got %h exp 00000003", reg_wdata); end
    checks++; if (pc_redirect !== 1'b0 || pc_target !== 2'd0) begin errors++; $display("FAIL nobranch got %b/%0d exp 0/0", pc_redirect, pc_target); end
    RegWrite = 0; Branch = 2'b01; inst_index = 26'h2; #1;
    checks++; if (pc_redirect !== 1'b1 || pc_target !== 2'd2) begin errors++; $display("FAIL jump got %b/%0d exp 1/2", pc_redirect, pc_target); end
    Branch = 2'b10; alu_result = 32'h1; #1;
    checks++; if (pc_redirect !== 1'b1 || pc_target !== 2'd1) begin errors++; $display("FAIL jr got %b/%0d exp 1/1", pc_redirect, pc_target); end
    Branch = 2'b11; pc2 = 2'd3; #1;
    checks++; if (pc_redirect !== 1'b1 || pc_target !== 2'd3) begin errors++; $display("FAIL branch got %b/%0d exp 1/3", pc_redirect, pc_target); end
    // UART read with RegWrite=0 on an empty FIFO must not stall
    Branch = 2'b00; UARTtoReg = 1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL uart_nowrite_stall got %b exp 0", stall); end
    tick();
  endtask

  task automatic test_uart_loaded();
    clear_inputs();
    rx_valid = 1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 0;
    uart_read(5'd8); #1;
    checks++; if (reg_we !== 1'b1 || reg_wdata !== 32'h41 || stall !== 1'b0) begin errors++; $display("FAIL uart_first got we=%b data=%h stall=%b exp 1/41/0", reg_we, reg_wdata, stall); end
    tick();
    checks++; if (reg_we !== 1'b1 || reg_wdata !== 32'h42 || stall !== 1'b0) begin errors++; $display("FAIL uart_second got we=%b data=%h stall=%b exp 1/42/0", reg_we, reg_wdata, stall); end
    tick();
  endtask

  task automatic test_uart_empty();
    // FIFO drained by the previous test; the held read now stalls
    uart_read(5'd8); Branch = 2'b01; inst_index = 26'h1;
    #1;
    checks++; if (stall !== 1'b1 || reg_we !== 1'b0) begin errors++; $display("FAIL empty_c1 got stall=%b we=%b exp 1/0", stall, reg_we); end
    checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL stall_redirect got %b exp 0", pc_redirect); end
    tick();
    checks++; if (stall !== 1'b1 || dbg_state !== 1'b1) begin errors++; $display("FAIL empty_c2 got stall=%b state=%b exp 1/1", stall, dbg_state); end
    tick();
    checks++; if (stall !== 1'b1 || reg_we !== 1'b0) begin errors++; $display("FAIL empty_c3 got stall=%b we=%b exp 1/0", stall, reg_we); end
    rx_valid = 1; rx_data = 8'h7F;
    tick();
    rx_valid = 0; #1;
    checks++; if (stall !== 1'b0 || reg_we !== 1'b1 || reg_wdata !== 32'h7F) begin errors++; $display("FAIL release got stall=%b we=%b data=%h exp 0/1/7f", stall, reg_we, reg_wdata); end
    checks++; if (pc_redirect !== 1'b1) begin errors++; $display("FAIL release_redirect got %b exp 1", pc_redirect); end
    tick();
    clear_inputs(); #1;
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL release_state got %b exp 0", dbg_state); end
  endtask

  task automatic test_full_wrap();
    logic [7:0] exp_q[$];
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1; rx_data = 8'hA0 + 8'(i); #1;
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1", i, rx_ready); end
      exp_q.push_back(rx_data);
      tick();
    end
    rx_data = 8'hA4; #1;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", rx_ready); end
    tick();
    rx_valid = 0; uart_read(5'd9); #1;
    checks++; if (reg_wdata !== {24'b0, exp_q[0]}) begin errors++; $display("FAIL full_pop got %h exp %h", reg_wdata, exp_q[0]); end
    void'(exp_q.pop_front());
    tick();
    // simultaneous push and pop across the pointer wrap
    rx_valid = 1; rx_data = 8'hA4; #1;
    checks++; if (rx_ready !== 1'b1 || reg_wdata !== {24'b0, exp_q[0]}) begin errors++; $display("FAIL pushpop got rdy=%b data=%h exp 1/%h", rx_ready, reg_wdata, exp_q[0]); end
    void'(exp_q.pop_front());
    exp_q.push_back(8'hA4);
    tick();
    rx_valid = 0;
    while (exp_q.size() > 0) begin
      #1;
      checks++; if (reg_we !== 1'b1 || reg_wdata !== {24'b0, exp_q[0]}) begin errors++; $display("FAIL drain got we=%b data=%h exp 1/%h", reg_we, reg_wdata, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL drained_stall got %b exp 1", stall); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    #1;
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL pre_reset_state got %b exp 1", dbg_state); end
    reset = 0; rx_valid = 1; rx_data = 8'h99; #1;
    checks++; if (stall !== 1'b0 || reg_we !== 1'b0 || rx_ready !== 1'b0) begin errors++; $display("FAIL mid_reset got stall=%b we=%b rdy=%b exp 0/0/0", stall, reg_we, rx_ready); end
    tick();
    reset = 1; clear_inputs(); #1;
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL post_reset_state got %b exp 0", dbg_state); end
    rx_valid = 1; rx_data = 8'h10; tick();
    rx_valid = 0; uart_read(5'd3); #1;
    checks++; if (stall !== 1'b0 || reg_we !== 1'b1 || reg_wdata !== 32'h10) begin errors++; $display("FAIL post_reset_read got stall=%b we=%b data=%h exp 0/1/10", stall, reg_we, reg_wdata); end
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    test_reset();
    test_alu_write();
    test_link_jumps();
    test_uart_loaded();
    test_uart_empty();
    test_full_wrap();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
